// File: rtl/lmac_cgmii_pkg.sv
// Shared CGMII character set, pause constants and RX decap FSM states.
package lmac_cgmii_pkg;

    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    localparam logic [15:0] ETH_PAUSE_TYPE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE   = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL
    } rx_state_e;

    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [5:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {11'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/rx_cgmii_decap_if.sv
// CGMII receive word in, realigned frame beats out.
interface rx_cgmii_decap_if #(
    parameter int DW = 256,
    parameter int CW = 32
);
    logic [DW-1:0] cgmii_rxd;
    logic [CW-1:0] cgmii_rxc;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_sop;
    logic          rx_eop;
    logic [4:0]    rx_mod;
    logic          rx_err;

    modport master (
        input  cgmii_rxd, cgmii_rxc,
        output rx_data, rx_valid, rx_sop, rx_eop, rx_mod, rx_err
    );

    modport slave (
        output cgmii_rxd, cgmii_rxc,
        input  rx_data, rx_valid, rx_sop, rx_eop, rx_mod, rx_err
    );
endinterface

// File: rtl/rx_cgmii_lane_scan.sv
// Finds the lowest lane holding /T/ and the lowest lane holding any
// other control character.
module rx_cgmii_lane_scan
    import lmac_cgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int CTRL_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rxd,
    input  logic [CTRL_WIDTH-1:0] rxc,
    output logic [4:0]            term_lane,
    output logic                  term_found,
    output logic [4:0]            bad_lane,
    output logic                  bad_found
);
    // Walk downwards so the lowest matching lane is the last one written.
    always_comb begin
        term_lane  = '0;
        term_found = 1'b0;
        bad_lane   = '0;
        bad_found  = 1'b0;
        for (int k = CTRL_WIDTH - 1; k >= 0; k--) begin
            if (rxc[k]) begin
                if (rxd[8*k +: 8] == CH_TERM) begin
                    term_lane  = 5'(k);
                    term_found = 1'b1;
                end else begin
                    bad_lane  = 5'(k);
                    bad_found = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rx_cgmii_decap.sv
// Receive CGMII decapsulation: strips /S/ and preamble, realigns frames
// to byte 0, flags pause frames and keeps good-frame statistics.
module rx_cgmii_decap
    import lmac_cgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int CTRL_WIDTH = 32,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 9600
) (
    input  logic             clk,
    input  logic             rst,
    rx_cgmii_decap_if.master bus,
    output logic             rx_pause,
    output logic [15:0]      rx_pvalue,
    output logic [31:0]      FMAC_RX_PKT_CNT,
    output logic [31:0]      FMAC_RX_BYTE_CNT,
    input  logic             fmac_rx_clr_en
);
    localparam int HOLD_W = DATA_WIDTH - 64;
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    rx_state_e         state;
    logic [HOLD_W-1:0] hold;
    logic [15:0]       len;
    logic [15:0]       eop_len;
    logic [15:0]       pause_q;
    logic              first;
    logic              pause_hit;
    logic              tail_err;
    logic [4:0]        tail_mod;

    logic [DATA_WIDTH-1:0] rxd;
    logic [CTRL_WIDTH-1:0] rxc;
    logic [4:0]  term_lane, bad_lane, end_lane;
    logic        term_found, bad_found;
    logic        do_term, do_bad, is_start, pause_det;
    logic [15:0] len_data, len_end, hold_pv;

    function automatic logic len_bad(input logic [15:0] l);
        return (l < MIN_LEN) || (l > MAX_LEN);
    endfunction

    assign rxd = bus.cgmii_rxd;
    assign rxc = bus.cgmii_rxc;

    rx_cgmii_lane_scan #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_scan (
        .rxd        (rxd),
        .rxc        (rxc),
        .term_lane  (term_lane),
        .term_found (term_found),
        .bad_lane   (bad_lane),
        .bad_found  (bad_found)
    );

    assign is_start = (rxc[7:0] == 8'h01) &&
                      (rxd[7:0] == CH_START) &&
                      (rxd[55:8] == {6{CH_PRE}}) &&
                      (rxd[63:56] == CH_SFD);

    // /T/ ends the frame only if no other control lane precedes it.
    assign do_term  = term_found && (!bad_found || term_lane < bad_lane);
    assign do_bad   = bad_found && !do_term;
    assign end_lane = do_term ? term_lane : bad_lane;
    assign len_data = sat_add(len, 6'd32);
    assign len_end  = sat_add(len, {1'b0, end_lane});

    assign pause_det = (hold[8*12 +: 8] == ETH_PAUSE_TYPE[15:8]) &&
                       (hold[8*13 +: 8] == ETH_PAUSE_TYPE[7:0]) &&
                       (hold[8*14 +: 8] == PAUSE_OPCODE[15:8]) &&
                       (hold[8*15 +: 8] == PAUSE_OPCODE[7:0]);
    assign hold_pv   = {hold[8*16 +: 8], hold[8*17 +: 8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            hold             <= '0;
            len              <= '0;
            eop_len          <= '0;
            pause_q          <= '0;
            first            <= 1'b0;
            pause_hit        <= 1'b0;
            tail_err         <= 1'b0;
            tail_mod         <= '0;
            bus.rx_data      <= '0;
            bus.rx_valid     <= 1'b0;
            bus.rx_sop       <= 1'b0;
            bus.rx_eop       <= 1'b0;
            bus.rx_mod       <= '0;
            bus.rx_err       <= 1'b0;
            rx_pause         <= 1'b0;
            rx_pvalue        <= '0;
            FMAC_RX_PKT_CNT  <= '0;
            FMAC_RX_BYTE_CNT <= '0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.rx_sop   <= 1'b0;
            bus.rx_eop   <= 1'b0;
            bus.rx_mod   <= '0;
            bus.rx_err   <= 1'b0;

            // Pause and statistics trail the registered EOP by one cycle.
            rx_pause <= bus.rx_eop && !bus.rx_err && pause_hit;
            if (bus.rx_eop && !bus.rx_err && pause_hit)
                rx_pvalue <= pause_q;

            if (fmac_rx_clr_en) begin
                FMAC_RX_PKT_CNT  <= '0;
                FMAC_RX_BYTE_CNT <= '0;
            end else if (bus.rx_eop && !bus.rx_err) begin
                FMAC_RX_PKT_CNT  <= FMAC_RX_PKT_CNT + 32'd1;
                FMAC_RX_BYTE_CNT <= FMAC_RX_BYTE_CNT + {16'b0, eop_len};
            end

            unique case (state)
                ST_IDLE: begin
                    if (is_start) begin
                        hold  <= rxd[DATA_WIDTH-1:64];
                        len   <= 16'd24;
                        first <= 1'b1;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    bus.rx_data  <= {rxd[63:0], hold};
                    bus.rx_valid <= 1'b1;
                    bus.rx_sop   <= first;
                    first        <= 1'b0;
                    if (first) begin
                        pause_hit <= pause_det;
                        pause_q   <= hold_pv;
                    end
                    if (!term_found && !bad_found) begin
                        hold <= rxd[DATA_WIDTH-1:64];
                        len  <= len_data;
                    end else if (end_lane <= 5'd8) begin
                        bus.rx_eop <= 1'b1;
                        bus.rx_mod <= end_lane + 5'd24;
                        bus.rx_err <= do_bad || len_bad(len_end);
                        eop_len    <= len_end;
                        state      <= ST_IDLE;
                    end else begin
                        hold     <= rxd[DATA_WIDTH-1:64];
                        len      <= len_end;
                        tail_mod <= end_lane - 5'd8;
                        tail_err <= do_bad;
                        state    <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    bus.rx_data  <= {{(DATA_WIDTH-HOLD_W){1'b0}}, hold};
                    bus.rx_valid <= 1'b1;
                    bus.rx_eop   <= 1'b1;
                    bus.rx_mod   <= tail_mod;
                    bus.rx_err   <= tail_err || len_bad(len);
                    eop_len      <= len;
                    // A /S/ here overwrites hold after the tail was read.
                    if (is_start) begin
                        hold  <= rxd[DATA_WIDTH-1:64];
                        len   <= 16'd24;
                        first <= 1'b1;
                        state <= ST_DATA;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_cgmii_decap.sv
// Randomized frame-level bench for rx_cgmii_decap with a byte-stream
// reference model and per-beat scoreboard.
module tb_rx_cgmii_decap;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fmac_rx_clr_en = 1'b0;
    logic        rx_pause;
    logic [15:0] rx_pvalue;
    logic [31:0] pkt_cnt;
    logic [31:0] byte_cnt;

    rx_cgmii_decap_if bus ();

    rx_cgmii_decap dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.master),
        .rx_pause         (rx_pause),
        .rx_pvalue        (rx_pvalue),
        .FMAC_RX_PKT_CNT  (pkt_cnt),
        .FMAC_RX_BYTE_CNT (byte_cnt),
        .fmac_rx_clr_en   (fmac_rx_clr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [255:0] m;
        bit           sop;
        bit           eop;
        bit           err;
        bit           pause;
        logic [4:0]   mod;
        logic [15:0]  pv;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t        exp_q[$];
    logic [255:0] wd_q[$];
    logic [31:0]  wc_q[$];
    logic [255:0] cur_d = '0;
    logic [31:0]  cur_c = '0;
    int           ln = 0;
    logic [31:0]  m_pkt = '0;
    logic [31:0]  m_byte = '0;
    bit           mon_en = 1'b0;
    bit           exp_pz = 1'b0;
    logic [15:0]  exp_pv = '0;
    beat_t        me;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_lane(input logic [7:0] b, input bit c);
        cur_d[8*ln +: 8] = b;
        cur_c[ln] = c;
        ln++;
        if (ln == 32) begin
            wd_q.push_back(cur_d);
            wc_q.push_back(cur_c);
            ln = 0;
        end
    endtask

    task automatic flush();
        while (ln != 0) put_lane(8'h07, 1'b1);
    endtask

    task automatic idle(input int n);
        flush();
        for (int i = 0; i < 32 * n; i++) put_lane(8'h07, 1'b1);
    endtask

    // kind 0: /T/ after n bytes, 1: error char after n bytes, 2: bad SFD
    task automatic gen_frame(input int n, input int kind, input bit pz,
                             input logic [15:0] q, input bit add_exp);
        logic [7:0] fb[$];
        beat_t      e;
        bit         good;
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
        if (pz) begin
            fb[12] = 8'h88; fb[13] = 8'h08;
            fb[14] = 8'h00; fb[15] = 8'h01;
            fb[16] = q[15:8]; fb[17] = q[7:0];
        end
        flush();
        put_lane(8'hFB, 1'b1);
        for (int i = 0; i < 6; i++) put_lane(8'h55, 1'b0);
        put_lane(kind == 2 ? 8'h55 : 8'hD5, 1'b0);
        foreach (fb[i]) put_lane(fb[i], 1'b0);
        put_lane(kind == 1 ? 8'hFE : 8'hFD, 1'b1);
        flush();
        if (!add_exp || kind == 2) return;
        good = (kind == 0) && (n >= 64) && (n <= 9600);
        for (int b = 0; b * 32 < n; b++) begin
            e.d = '0;
            e.m = '0;
            for (int j = 0; j < 32 && b * 32 + j < n; j++) begin
                e.d[8*j +: 8] = fb[b*32+j];
                e.m[8*j +: 8] = 8'hFF;
            end
            e.sop   = (b == 0);
            e.eop   = ((b + 1) * 32 >= n);
            e.mod   = 5'(n % 32);
            e.err   = !good;
            e.pause = good && fb[12] == 8'h88 && fb[13] == 8'h08 &&
                      fb[14] == 8'h00 && fb[15] == 8'h01;
            e.pv    = {fb[16], fb[17]};
            exp_q.push_back(e);
        end
        if (good) begin
            m_pkt  = m_pkt + 32'd1;
            m_byte = m_byte + 32'(n);
        end
    endtask

    task automatic drive_all();
        while (wd_q.size() > 0) begin
            @(posedge clk); #1;
            bus.cgmii_rxd = wd_q.pop_front();
            bus.cgmii_rxc = wc_q.pop_front();
        end
        @(posedge clk); #1;
        bus.cgmii_rxd = {32{8'h07}};
        bus.cgmii_rxc = '1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", 256'(exp_q.size()), '0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_pkt"}, 256'(pkt_cnt), 256'(m_pkt));
        chk({tag, "_byte"}, 256'(byte_cnt), 256'(m_byte));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_pause || exp_pz)
                chk("rx_pause", 256'(rx_pause), 256'(exp_pz));
            if (exp_pz)
                chk("rx_pvalue", 256'(rx_pvalue), 256'(exp_pv));
            exp_pz = 1'b0;
            if (bus.rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 256'(bus.rx_valid), '0);
                end else begin
                    me = exp_q.pop_front();
                    chk("rx_data", bus.rx_data & me.m, me.d);
                    chk("rx_sop", 256'(bus.rx_sop), 256'(me.sop));
                    chk("rx_eop", 256'(bus.rx_eop), 256'(me.eop));
                    if (me.eop) begin
                        chk("rx_mod", 256'(bus.rx_mod), 256'(me.mod));
                        chk("rx_err", 256'(bus.rx_err), 256'(me.err));
                        exp_pz = me.pause;
                        exp_pv = me.pv;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  kind, n, k, vcnt;
        bit  pz;
        bus.cgmii_rxd = {32{8'h07}};
        bus.cgmii_rxc = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 256'(bus.rx_valid), '0);
        chk("rst_sop", 256'(bus.rx_sop), '0);
        chk("rst_eop", 256'(bus.rx_eop), '0);
        chk("rst_err", 256'(bus.rx_err), '0);
        chk("rst_mod", 256'(bus.rx_mod), '0);
        chk("rst_data", bus.rx_data, '0);
        chk("rst_pause", 256'(rx_pause), '0);
        chk("rst_pvalue", 256'(rx_pvalue), '0);
        chk_cnt("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        gen_frame(64, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        drive_all();
        drain();
        chk_cnt("first64");

        gen_frame(100, 0, 1'b0, 16'h0, 1'b1);
        gen_frame(70, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        gen_frame(64, 0, 1'b1, 16'h1234, 1'b1);
        idle(2);
        gen_frame(61, 1, 1'b0, 16'h0, 1'b1);
        gen_frame(80, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        gen_frame(90, 2, 1'b0, 16'h0, 1'b1);
        gen_frame(40, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        gen_frame(63, 0, 1'b0, 16'h0, 1'b1);
        gen_frame(76, 1, 1'b0, 16'h0, 1'b1);
        gen_frame(24, 0, 1'b0, 16'h0, 1'b1);
        gen_frame(9600, 0, 1'b0, 16'h0, 1'b1);
        gen_frame(9601, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        drive_all();
        drain();
        chk_cnt("directed");

        for (int r = 0; r < 40; r++) begin
            k    = $urandom_range(0, 9);
            kind = (k < 7) ? 0 : ((k < 9) ? 1 : 2);
            n    = $urandom_range(24, 300);
            pz   = ($urandom_range(0, 3) == 0);
            gen_frame(n, kind, pz, 16'($urandom), 1'b1);
            idle($urandom_range(0, 2));
        end
        drive_all();
        drain();
        chk_cnt("random");

        gen_frame(64, 0, 1'b0, 16'h0, 1'b1);
        fork
            drive_all();
        join_none
        k = 0;
        @(negedge clk);
        while (!bus.rx_eop && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("clr_eop_seen", 256'(bus.rx_eop), 256'(1));
        fmac_rx_clr_en = 1'b1;
        @(posedge clk); #1;
        fmac_rx_clr_en = 1'b0;
        @(negedge clk);
        chk("clr_pkt", 256'(pkt_cnt), '0);
        chk("clr_byte", 256'(byte_cnt), '0);
        wait fork;
        drain();
        m_pkt  = '0;
        m_byte = '0;
        gen_frame(70, 0, 1'b0, 16'h0, 1'b1);
        idle(1);
        drive_all();
        drain();
        chk_cnt("after_clr");

        mon_en = 1'b0;
        exp_pz = 1'b0;
        gen_frame(200, 0, 1'b0, 16'h0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            bus.cgmii_rxd = wd_q.pop_front();
            bus.cgmii_rxc = wc_q.pop_front();
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.cgmii_rxd = wd_q.pop_front();
        bus.cgmii_rxc = wc_q.pop_front();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 256'(bus.rx_valid), '0);
        chk("mid_rst_eop", 256'(bus.rx_eop), '0);
        chk("mid_rst_data", bus.rx_data, '0);
        chk("mid_rst_pkt", 256'(pkt_cnt), '0);
        vcnt = 0;
        while (wd_q.size() > 0) begin
            @(posedge clk); #1;
            bus.cgmii_rxd = wd_q.pop_front();
            bus.cgmii_rxc = wc_q.pop_front();
            @(negedge clk);
            if (bus.rx_valid) vcnt++;
        end
        @(posedge clk); #1;
        bus.cgmii_rxd = {32{8'h07}};
        bus.cgmii_rxc = '1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rx_valid) vcnt++;
        end
        chk("mid_rst_no_valid", 256'(vcnt), '0);

        m_pkt  = '0;
        m_byte = '0;
        mon_en = 1'b1;
        gen_frame(128, 0, 1'b1, 16'hBEEF, 1'b1);
        idle(1);
        drive_all();
        drain();
        chk_cnt("recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_cgmii_decap.md
Name: rx_cgmii_decap

Overview:
- Receive-side counterpart of the 256-bit CGMII transmit path.
- Consumes 32-lane CGMII receive words, locates /S/…/T/ frames and checks/strips the 8-byte preamble.
- Realigns the frame to byte 0 and writes 256-bit beats with SOP/EOP/byte-count toward the RX FIFO.
- Decodes received MAC-control pause frames into the rx_pause/rx_pvalue handshake used by tx_encap, and keeps RX packet/byte statistics. FCS is not checked here; the downstream CRC checker does that.

Parameters:
DATA_WIDTH, 256, CGMII data width (32 byte lanes)
CTRL_WIDTH, 32, one control bit per lane
MIN_FRAME, 64, minimum legal frame length in bytes, FCS included
MAX_FRAME, 9600, maximum legal frame length in bytes

Ports:
clk  in  1  receive clock
rst  in  1  synchronous reset, active high
cgmii_rxd  in  256  lane k = bits [8k+7:8k]; lane 0 is first on the wire
cgmii_rxc  in  32  bit k=1: lane k carries a control character
rx_data  out  256  realigned frame data; frame byte j in lane j of each beat
rx_valid  out  1  rx_data is valid this cycle
rx_sop  out  1  first beat of frame
rx_eop  out  1  last beat of frame
rx_mod  out  5  valid bytes in EOP beat; 0 means 32
rx_err  out  1  frame bad; qualified by rx_eop
rx_pause  out  1  one-cycle pulse: good pause frame received
rx_pvalue  out  16  pause quanta; held until next pause
FMAC_RX_PKT_CNT  out  32  good frames received
FMAC_RX_BYTE_CNT  out  32  bytes of good frames, FCS included
fmac_rx_clr_en  in  1  synchronous clear of both counters

Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All outputs are registered.

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- Reset asserted mid-frame discards the frame; no EOP is emitted.

Characters:
- /S/ = 0xFB in lane 0 only.
- /T/ = 0xFD.
- Preamble: lanes 1–6 = 0x55 and lane 7 = 0xD5, all with rxc=0.
- /S/ in any other lane is ignored while in IDLE.

FSM states: IDLE, DATA, TAIL.
- IDLE → DATA: on a valid /S/ plus preamble. Load the hold register with lanes 8–31; emit nothing.
- Bad preamble: the frame is silently dropped and the FSM stays in IDLE.
- DATA, beat with no control lanes: output {lanes 0–7 of current beat, 24 held bytes} and reload the hold register with lanes 8–31. rx_sop is set on the first output of the frame. Latency from wire to output is 1 cycle.
- DATA, /T/ in lane t with lanes 0..t-1 data:
  - t ≤ 8: output is the EOP beat, rx_mod = (24+t) mod 32; go to IDLE.
  - t > 8: output a full non-EOP beat; the next cycle emits EOP with rx_mod = t-8; go to TAIL.
- TAIL: emit the tail from the hold register → IDLE.
  - A /S/ arriving in the TAIL cycle is accepted; the hold register is reloaded in the same edge after the tail is read. Back-to-back frames need no extra idle beat.
- DATA, control character other than /T/ in a data lane, or /S/ anywhere:
  - Emit EOP with rx_err=1 and the bytes up to the offending lane; go to IDLE.
  - A new /S/ seen here is not started.

Length:
- 16-bit running counter, saturating at 0xFFFF; counts frame bytes after the SFD, FCS included.
- At EOP, length < MIN_FRAME or > MAX_FRAME sets rx_err.
- The data beats are still delivered.

Pause detection (first output beat):
- Frame bytes 12–13 = 0x88,0x08 and 14–15 = 0x00,0x01.
- If the frame ends with rx_err=0, pulse rx_pause for the cycle after EOP and set rx_pvalue = {byte16, byte17}.
- Pause frames are still forwarded on rx_data.

Counters:
- On an EOP with rx_err=0: PKT_CNT += 1 and BYTE_CNT += length.
- Both counters wrap modulo 2^32.
- fmac_rx_clr_en zeroes both counters and wins over a simultaneous increment.

Decomposition:
- Shared package `lmac_cgmii_pkg`: character constants (START 0xFB, TERM 0xFD, IDLE 0x07, PRE 0x55, SFD 0xD5), ETH_PAUSE_TYPE 0x8808, PAUSE_OPCODE 0x0001, FSM state enum.
- One natural sub-module, `rx_cgmii_lane_scan`: combinational first-/T/ and first-bad-control lane finder, producing a 5-bit index plus a found flag. Everything else stays in the top level.

Test Plan:
- 64-byte frame, /S/ at beat 0, /T/ at lane 8 of beat 2 → 2 output beats; SOP on the first; EOP with rx_mod=0 (32); rx_err=0; PKT_CNT=1, BYTE_CNT=64.
- 100-byte frame (/T/ at lane 12 of beat 3) immediately followed by /S/ in the next beat → TAIL beat with rx_mod=4; second frame's SOP arrives with no gap; both counted.
- Pause frame with type 0x8808, opcode 0x0001, quanta 0x1234 → rx_pause pulses once the cycle after EOP; rx_pvalue=0x1234.
- Error character 0xFE with rxc=1 in lane 5 mid-frame → EOP with rx_err=1; counters unchanged; next good frame decoded normally.
- Preamble lane 7 = 0x55 (bad SFD) → no rx_valid for that frame; a 40-byte frame → EOP with rx_err=1 (runt).
- fmac_rx_clr_en asserted on the same cycle as a good EOP → both counters read 0 next cycle; rst mid-frame → no EOP emitted; outputs 0.
